// File: rtl/kyber_modmul_pipe.sv
// Kyber modular multiplier: (a*b) mod Q via Barrett reduction in a 3-stage
// valid/ready pipeline with whole-pipe backpressure and a sideband tag.
module kyber_modmul_pipe #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [11:0]      a_i,
  input  logic [11:0]      b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [11:0]      r_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o,
  output logic             range_err_o
);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The whole pipe advances together whenever the output slot is empty or
  // being taken, so in_ready_o never depends on in_valid_i.
  localparam logic [39:0] MU  = 40'd20159;
  localparam logic [25:0] Q26 = 26'(Q);
  localparam logic [11:0] Q12 = 12'(Q);

  logic              adv;
  logic              accept;

  logic              v1;
  logic [23:0]       p1;
  logic [TAG_W-1:0]  tag1;

  logic              v2;
  logic [23:0]       p2;
  logic [13:0]       t2;
  logic [TAG_W-1:0]  tag2;

  logic [13:0]       t_next;
  logic signed [25:0] r_raw;
  logic signed [25:0] r_fix;
  logic [11:0]       r_next;

  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = adv;
  assign accept     = in_valid_i && adv;
  assign busy_o     = v1 | v2 | out_valid_o;

  // Quotient estimate; the full 40-bit product is kept until after the shift.
  assign t_next = 14'((40'(p1) * MU) >> 26);

  // The estimate may be off by one in either direction, so a single
  // conditional add or subtract of Q lands the result in [0,Q-1].
  always_comb begin
    r_raw = $signed({2'b00, p2}) - $signed(26'(t2) * Q26);
    r_fix = r_raw;
    if (r_raw < 0) begin
      r_fix = r_raw + $signed(Q26);
    end else if (r_raw >= $signed(Q26)) begin
      r_fix = r_raw - $signed(Q26);
    end
  end

  assign r_next = 12'(r_fix);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1          <= 1'b0;
      p1          <= '0;
      tag1        <= '0;
      v2          <= 1'b0;
      p2          <= '0;
      t2          <= '0;
      tag2        <= '0;
      out_valid_o <= 1'b0;
      r_o         <= '0;
      tag_o       <= '0;
      range_err_o <= 1'b0;
    end else if (clear_i) begin
      // Flush wins over any accept in the same cycle.
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      range_err_o <= 1'b0;
    end else begin
      if (accept && (a_i >= Q12 || b_i >= Q12)) begin
        range_err_o <= 1'b1;
      end
      if (adv) begin
        v1          <= accept;
        p1          <= 24'(a_i) * 24'(b_i);
        tag1        <= tag_i;
        v2          <= v1;
        p2          <= p1;
        t2          <= t_next;
        tag2        <= tag1;
        out_valid_o <= v2;
        r_o         <= r_next;
        tag_o       <= tag2;
      end
    end
  end

endmodule
